sha256_hash_sequencer: RTL and testbench

SHA256_HASH_SEQUENCER -- requirements
Module: sha256_hash_sequencer

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_hash_adder.sv | 18 +
 rtl/sha256_hash_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sha256_hash_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the hash sequencer.
//   SHA256_IV : initial chaining value H0..H7, H0 in bits [255:224]
//   state_e   : block sequencer FSM states
package sha256_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StUpdate,
        StOutput
    } state_e;

endpackage

// File: rtl/sha256_hash_adder.sv
// Eight-lane modulo-2^32 adder used to fold engine working variables into
// the chaining state. Purely combinational; lanes never carry into each other.
//   a, b : packed 8 x 32-bit operands, lane 0 in bits [255:224]
//   sum  : per-lane a + b mod 2^32
module sha256_hash_adder (
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
    end

endmodule

// File: rtl/sha256_hash_sequencer.sv
// SHA-256 block sequencer: accepts padded 512-bit blocks, hands each to an
// external compression engine together with the current chaining state,
// folds the returned working variables into H and emits the digest after
// the last block of a message.
//   clk, nrst, en, sync_rst             : clock, async reset, enable, sync clear
//   data_in*                            : block input handshake
//   eng_block/hash/id/valid, eng_ready  : engine request handshake
//   eng_result*, eng_result_ready       : engine response (a..h, a in [255:224])
//   data_out*                           : digest output handshake
//   busy, id_err (sticky), block_count  : status
module sha256_hash_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned ID_W = 6
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic            sync_rst,
    input  logic [511:0]    data_in,
    input  logic [ID_W-1:0] data_in_id,
    input  logic            data_in_last,
    input  logic            data_in_valid,
    output logic            data_in_ready,
    output logic [511:0]    eng_block,
    output logic [255:0]    eng_hash,
    output logic [ID_W-1:0] eng_id,
    output logic            eng_valid,
    input  logic            eng_ready,
    input  logic [255:0]    eng_result,
    input  logic            eng_result_valid,
    output logic            eng_result_ready,
    output logic [255:0]    data_out,
    output logic [ID_W-1:0] data_out_id,
    output logic            data_out_valid,
    input  logic            data_out_ready,
    output logic            busy,
    output logic            id_err,
    output logic [15:0]     block_count
);

    state_e            state_q, state_d;
    // Low for the first enabled cycle after any reset so data_in_ready stays 0 in reset.
    logic              run_q;
    logic [511:0]      blk_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   msg_id_q;
    logic              last_q;
    // Set when the next accepted block starts a new message.
    logic              first_q;
    logic [255:0]      h_q;
    logic [255:0]      res_q;
    logic [255:0]      h_sum;
    logic [15:0]       cnt_q;
    logic              id_err_q;

    logic in_xfer, eng_xfer, res_xfer, out_xfer;

    // Transfers are decoded from state directly to keep the handshake free of
    // combinational feedback through the ready/valid outputs.
    assign in_xfer  = en && run_q && data_in_valid && (state_q == StIdle);
    assign eng_xfer = en && eng_ready && (state_q == StIssue);
    assign res_xfer = en && eng_result_valid && (state_q == StWait);
    assign out_xfer = en && data_out_ready && (state_q == StOutput);

    sha256_hash_adder u_adder (
        .a   (h_q),
        .b   (res_q),
        .sum (h_sum)
    );

    always_comb begin
        state_d          = state_q;
        data_in_ready    = 1'b0;
        eng_valid        = 1'b0;
        eng_result_ready = 1'b0;
        data_out_valid   = 1'b0;
        eng_block        = '0;
        eng_hash         = '0;
        eng_id           = '0;
        data_out         = '0;
        data_out_id      = '0;
        unique case (state_q)
            StIdle: begin
                data_in_ready = run_q;
                if (in_xfer) state_d = StIssue;
            end
            StIssue: begin
                eng_valid = 1'b1;
                eng_block = blk_q;
                eng_hash  = h_q;
                eng_id    = id_q;
                if (eng_xfer) state_d = StWait;
            end
            StWait: begin
                eng_result_ready = 1'b1;
                if (res_xfer) state_d = StUpdate;
            end
            StUpdate: begin
                state_d = last_q ? StOutput : StIdle;
            end
            StOutput: begin
                data_out_valid = 1'b1;
                data_out       = h_q;
                data_out_id    = id_q;
                if (out_xfer) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // sync_rst takes effect regardless of en, exactly like nrst.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            run_q    <= 1'b0;
            blk_q    <= '0;
            id_q     <= '0;
            msg_id_q <= '0;
            last_q   <= 1'b0;
            first_q  <= 1'b1;
            h_q      <= SHA256_IV;
            res_q    <= '0;
            cnt_q    <= '0;
            id_err_q <= 1'b0;
        end else if (sync_rst) begin
            state_q  <= StIdle;
            run_q    <= 1'b0;
            blk_q    <= '0;
            id_q     <= '0;
            msg_id_q <= '0;
            last_q   <= 1'b0;
            first_q  <= 1'b1;
            h_q      <= SHA256_IV;
            res_q    <= '0;
            cnt_q    <= '0;
            id_err_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (in_xfer) begin
                blk_q   <= data_in;
                id_q    <= data_in_id;
                last_q  <= data_in_last;
                first_q <= data_in_last;
                if (first_q) begin
                    msg_id_q <= data_in_id;
                end else if (data_in_id != msg_id_q) begin
                    id_err_q <= 1'b1;
                end
            end
            if (res_xfer) res_q <= eng_result;
            if (state_q == StUpdate) begin
                h_q   <= h_sum;
                cnt_q <= cnt_q + 16'd1;
            end
            if (out_xfer) h_q <= SHA256_IV;
        end
    end

    assign busy        = (state_q != StIdle);
    assign id_err      = id_err_q;
    assign block_count = cnt_q;

endmodule

// File: tb/tb_sha256_hash_sequencer.sv
module tb_sha256_hash_sequencer;

    localparam int unsigned ID_W = 6;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic            clk = 1'b0;
    logic            nrst, en, sync_rst;
    logic [511:0]    data_in;
    logic [ID_W-1:0] data_in_id;
    logic            data_in_last, data_in_valid, data_in_ready;
    logic [511:0]    eng_block;
    logic [255:0]    eng_hash;
    logic [ID_W-1:0] eng_id;
    logic            eng_valid, eng_ready;
    logic [255:0]    eng_result;
    logic            eng_result_valid, eng_result_ready;
    logic [255:0]    data_out;
    logic [ID_W-1:0] data_out_id;
    logic            data_out_valid, data_out_ready;
    logic            busy, id_err;
    logic [15:0]     block_count;

    always #5 clk = ~clk;

    sha256_hash_sequencer #(.ID_W(ID_W)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .en               (en),
        .sync_rst         (sync_rst),
        .data_in          (data_in),
        .data_in_id       (data_in_id),
        .data_in_last     (data_in_last),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .eng_block        (eng_block),
        .eng_hash         (eng_hash),
        .eng_id           (eng_id),
        .eng_valid        (eng_valid),
        .eng_ready        (eng_ready),
        .eng_result       (eng_result),
        .eng_result_valid (eng_result_valid),
        .eng_result_ready (eng_result_ready),
        .data_out         (data_out),
        .data_out_id      (data_out_id),
        .data_out_valid   (data_out_valid),
        .data_out_ready   (data_out_ready),
        .busy             (busy),
        .id_err           (id_err),
        .block_count      (block_count)
    );

    typedef struct packed {
        logic [255:0]    dig;
        logic [ID_W-1:0] id;
        logic [15:0]     cnt;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   lat_min = 0;
    int   lat_max = 2;
    bit   en_rand = 1'b0;
    bit   dor_rand = 1'b0;
    logic [255:0]    last_dig = '0;
    logic [ID_W-1:0] last_id = '0;
    logic [15:0]     last_cnt = '0;

    // Reference model state: message-level view of SHA-256 chaining.
    logic [255:0]    m_h;
    logic [15:0]     m_cnt;
    logic            m_err, m_first;
    logic [ID_W-1:0] m_msgid;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // 64 SHA-256 rounds; returns raw working variables a..h (no feed-forward).
    function automatic logic [255:0] compress_vars(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, hh};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_h = IV; m_cnt = '0; m_err = 1'b0; m_first = 1'b1; m_msgid = '0;
    endtask

    task automatic send_block(input logic [511:0] blk, input logic [ID_W-1:0] id,
                              input logic last);
        bit got;
        exp_t e;
        data_in = blk; data_in_id = id; data_in_last = last; data_in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 3000 && !got; t++) begin
            @(negedge clk);
            got = en && data_in_ready;
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        chk("in_handshake", 256'(got), 256'(1));
        if (m_first) m_msgid = id;
        else if (id != m_msgid) m_err = 1'b1;
        m_first = last;
        m_h = add_words(m_h, compress_vars(m_h, blk));
        m_cnt = m_cnt + 16'd1;
        if (last) begin
            e.dig = m_h; e.id = id; e.cnt = m_cnt; e.err = m_err;
            exp_q.push_back(e);
            m_h = IV;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !busy;
        end
        chk("drain", 256'(ok), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = data_out_valid;
        end
        chk("out_valid_wait", 256'(ok), 256'(1));
    endtask

    // Compression engine stand-in; after a reset it keeps a stale result up
    // for a few cycles to make sure the sequencer does not pick it up.
    initial begin : engine
        logic [255:0] pend, cap_hash;
        logic [511:0] cap_blk;
        int wait_cnt, stale;
        bit pending, acc, done, rst_seen;
        eng_ready = 1'b0; eng_result_valid = 1'b0; eng_result = '0;
        pend = '0; cap_hash = '0; cap_blk = '0; wait_cnt = 0; stale = 0; pending = 1'b0;
        forever begin
            @(negedge clk);
            rst_seen = !nrst || sync_rst;
            acc      = en && eng_valid && eng_ready;
            done     = en && eng_result_valid && eng_result_ready;
            cap_blk  = eng_block;
            cap_hash = eng_hash;
            @(posedge clk);
            #1;
            if (rst_seen) begin
                stale = (pending || eng_result_valid) ? 4 : 0;
                if (pending) eng_result = pend;
                if (stale > 0) eng_result_valid = 1'b1;
                pending = 1'b0;
                eng_ready = 1'b0;
            end else if (stale > 0) begin
                stale--;
                if (stale == 0) eng_result_valid = 1'b0;
            end else begin
                if (done) begin
                    eng_result_valid = 1'b0;
                    pending = 1'b0;
                end
                if (acc) begin
                    pend = compress_vars(cap_hash, cap_blk);
                    pending = 1'b1;
                    eng_ready = 1'b0;
                    wait_cnt = int'($urandom_range(lat_max, lat_min));
                end else if (pending && !eng_result_valid) begin
                    if (wait_cnt == 0) begin
                        eng_result = pend;
                        eng_result_valid = 1'b1;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (!pending) eng_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && !sync_rst && en && data_out_valid && data_out_ready) begin
                n_out++;
                last_dig = data_out; last_id = data_out_id; last_cnt = block_count;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, none outstanding", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_digest", data_out, e.dig);
                    chk("out_id", 256'(data_out_id), 256'(e.id));
                    chk("out_block_count", 256'(block_count), 256'(e.cnt));
                    chk("out_id_err", 256'(id_err), 256'(e.err));
                end
            end
        end
    end

    initial begin : rand_en
        forever begin
            @(posedge clk);
            #1;
            if (en_rand) en = ($urandom_range(0, 4) != 0);
            if (dor_rand) data_out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        logic [511:0]    blk;
        logic [ID_W-1:0] id;
        int nb;
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0; data_out_ready = 1'b1;
        data_in = '0; data_in_id = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data_in_ready", 256'(data_in_ready), 256'(0));
        chk("rst_eng_valid", 256'(eng_valid), 256'(0));
        chk("rst_eng_result_ready", 256'(eng_result_ready), 256'(0));
        chk("rst_data_out_valid", 256'(data_out_valid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_block_count", 256'(block_count), 256'(0));
        chk("rst_id_err", 256'(id_err), 256'(0));
        chk("rst_data_out", data_out, 256'(0));
        chk("rst_eng_hash", eng_hash, 256'(0));
        chk("rst_eng_block", 256'(eng_block[255:0] | eng_block[511:256]), 256'(0));
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Single-block "abc"
        send_block(ABC_BLK, 6'd3, 1'b1);
        wait_done();
        chk("abc_digest", last_dig, ABC_DIG);
        chk("abc_id", 256'(last_id), 256'(3));
        chk("abc_block_count", 256'(last_cnt), 256'(1));

        // Two-block message: exactly one digest
        n0 = n_out;
        send_block(TWO_B1, 6'd7, 1'b0);
        send_block(TWO_B2, 6'd7, 1'b1);
        wait_done();
        chk("two_digest", last_dig, TWO_DIG);
        chk("two_outputs", 256'(n_out - n0), 256'(1));
        chk("two_block_count", 256'(last_cnt), 256'(3));

        // Output back-pressure for 10 cycles, then a second identical message
        data_out_ready = 1'b0;
        send_block(ABC_BLK, 6'd9, 1'b1);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_data_out", data_out, ABC_DIG);
            chk("hold_out_valid", 256'(data_out_valid), 256'(1));
            chk("hold_in_ready", 256'(data_in_ready), 256'(0));
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        send_block(ABC_BLK, 6'd9, 1'b1);
        wait_done();
        chk("b2b_second_digest", last_dig, ABC_DIG);

        // Id mismatch on second block: flagged, still processed, sticky
        send_block(TWO_B1, 6'd5, 1'b0);
        send_block(TWO_B2, 6'd6, 1'b1);
        wait_done();
        chk("idmm_digest", last_dig, TWO_DIG);
        chk("idmm_id_err", 256'(id_err), 256'(1));
        send_block(ABC_BLK, 6'd3, 1'b1);
        wait_done();
        chk("idmm_sticky", 256'(id_err), 256'(1));

        // sync_rst while waiting on the engine
        lat_min = 6; lat_max = 6;
        send_block(ABC_BLK, 6'd2, 1'b1);
        begin
            bit ok;
            ok = 1'b0;
            for (int t = 0; t < 500 && !ok; t++) begin
                @(negedge clk);
                ok = eng_result_ready;
            end
            chk("reach_wait", 256'(ok), 256'(1));
        end
        @(posedge clk);
        #1;
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        exp_q.delete();
        model_reset();
        lat_min = 0; lat_max = 2;
        @(negedge clk);
        chk("srst_busy", 256'(busy), 256'(0));
        chk("srst_out_valid", 256'(data_out_valid), 256'(0));
        chk("srst_block_count", 256'(block_count), 256'(0));
        chk("srst_id_err", 256'(id_err), 256'(0));
        chk("srst_stale_valid", 256'(eng_result_valid), 256'(1));
        chk("srst_stale_ignored", 256'(eng_result_ready), 256'(0));
        send_block(ABC_BLK, 6'd4, 1'b1);
        wait_done();
        chk("srst_abc_digest", last_dig, ABC_DIG);
        chk("srst_abc_count", 256'(last_cnt), 256'(1));

        // en low for 5 cycles in ISSUE and in OUTPUT
        data_out_ready = 1'b0;
        send_block(ABC_BLK, 6'd1, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frz_issue_valid", 256'(eng_valid), 256'(1));
            chk("frz_issue_hash", eng_hash, IV);
            chk("frz_issue_id", 256'(eng_id), 256'(1));
            chk("frz_issue_count", 256'(block_count), 256'(1));
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_out_valid();
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frz_out_valid", 256'(data_out_valid), 256'(1));
            chk("frz_out_data", data_out, ABC_DIG);
            chk("frz_out_count", 256'(block_count), 256'(2));
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        data_out_ready = 1'b1;
        wait_done();
        chk("frz_digest", last_dig, ABC_DIG);

        // Randomized messages with random enable, back-pressure and engine latency
        lat_min = 0; lat_max = 5;
        en_rand = 1'b1; dor_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            nb = int'($urandom_range(1, 3));
            id = ID_W'($urandom);
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom;
                send_block(blk, (b > 0 && $urandom_range(0, 7) == 0) ? id + 1'b1 : id,
                           (b == nb - 1));
            end
        end
        wait_done();
        en_rand = 1'b0; dor_rand = 1'b0;
        en = 1'b1; data_out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
